nec_prefetch_queue: RTL and testbench
=====================================

// Module: nec_prefetch_queue
// PURPOSE
// - Producer side of the instruction prefetch queue (IPQ) read by the instruction decoder.
// - Fetches code bytes from PS:PC over a request/ack bus port and fills an 8-entry byte
//   queue; each byte is stored at slot = address[2:0].
// - Exports ipq/ipq_len; retires bytes on decoder consume; flushes and restarts on a branch.
// PARAMETERS
// - DEPTH      8   queue bytes; fixed at 8 (slot index is addr[2:0]); ipq_len range 0..8
// - FETCH_MIN  2   minimum free bytes before a word fetch is issued (1 for an odd address)
// PORTS
// - clk             in   1      clock
// - reset_n         in   1      asynchronous active-low reset
// - ce              in   1      clock enable; all state updates gated by ce
// - flush           in   1      discard queue, restart fetching at flush_pc
// - flush_pc        in   16     new PC (offset within PS)
// - ps              in   16     program segment register
// - consume         in   1      decoder retires consume_len bytes from head
// - consume_len     in   4      bytes retired (0..ipq_len)
// - ipq             out  8x8    queue storage; byte at PC p is ipq[p[2:0]]
// - ipq_len         out  4      valid bytes from head_pc
// - head_pc         out  16     PC of first valid byte
// - fetch_req       out  1      bus read request; held until fetch_ack
// - fetch_addr      out  20     word-aligned physical address ({ps,4'h0} + fetch_pc) & ~1, mod 2^20
// - fetch_ack       in   1      bus read complete, fetch_data valid this cycle
// - fetch_data      in   16     little-endian read data
// BEHAVIOUR
// - Reset: ipq_len=0, head_pc=0, fetch_pc=0, fetch_req=0, fetch_addr=0, all ipq bytes 0, state IDLE.
// - fetch_pc = head_pc + ipq_len (16-bit, wraps 0xFFFF->0x0000 inside the segment).
// - Three-state FSM:
//   - IDLE:
//     - issue when free = 8 - ipq_len >= need, where need = 1 if fetch_pc odd, else FETCH_MIN.
//     - on issue: fetch_req<=1, latch fetch_addr, go REQ.
//   - REQ:
//     - on fetch_ack, write bytes and return to IDLE.
//     - a new request may be issued the cycle after the ack, never the same cycle.
//     - word write: even fetch_pc writes 2 bytes (lo at slot fetch_pc[2:0], hi at +1); odd
//       fetch_pc writes only the hi byte at slot fetch_pc[2:0].
//     - ipq_len grows by the bytes written.
//   - DISCARD: entered when flush arrives in REQ without ack; keep fetch_req=1; on fetch_ack drop
//     data, fetch_req<=0, go IDLE.
// - Flush:
//   - head_pc<=flush_pc, ipq_len<=0.
//   - flush has priority over consume and fetch_ack in the same cycle; ack data is dropped.
//   - flush + ack in REQ -> IDLE, not DISCARD.
// - Consume: head_pc += consume_len, ipq_len -= consume_len.
// - Same-cycle consume + ack: ipq_len <= ipq_len - consume_len + written.
//   - Free space for the next issue is evaluated on the registered ipq_len.
// - consume_len > ipq_len is illegal (simulation assertion); RTL clamps ipq_len at 0.
// - ipq_len never exceeds 8.
// - Latency: request to data in ipq = bus latency + 1 clk (registered write).
// - fetch_addr wraps modulo 2^20; physical wrap is independent of 16-bit PC wrap.
// - ce=0: all state and outputs hold; fetch_req stays asserted if already high.
// - reset_n asserted mid-request: immediate return to reset values; a late ack is ignored (IDLE).
// CONFIGURATION
// - PREFETCH_8BIT_BUS_EN defined (V20-style 8-bit bus):
//   - fetch_addr is the byte address (no alignment).
//   - each ack writes fetch_data[7:0] to one slot; need=1.
// - PREFETCH_8BIT_BUS_EN undefined: 16-bit word fetch as above.
// TESTING
// - Reset; ps=0x1000, flush_pc=0x0100, acks return 0x3412,0x7856,...
//   -> fetch_addr 0x10100,0x10102,...; ipq_len 2,4,6,8; stalls at 8; ipq[0]=0x12, ipq[1]=0x34.
// - flush_pc=0x0103 -> first fetch_addr 0x10102, only hi byte stored at slot 3,
//   ipq_len=1; next fetch_addr 0x10104.
// - Full queue (len 8), consume_len=3 -> ipq_len=5, head_pc+3; fetch reissued next cycle
//   at fetch_pc=head_pc+5.
// - Flush while in REQ (no ack) -> DISCARD; following ack leaves ipq_len=0; next fetch at new flush_pc.
// - Same-cycle consume_len=2 + word ack with ipq_len=4 -> ipq_len=4.
//   Same-cycle flush + ack -> ipq_len=0, state IDLE.
// - head_pc=0xFFFE, ps=0xF000 -> fetch addr 0xFFFFE, then 0xF0000 (PC 0x0000);
//   with PREFETCH_8BIT_BUS_EN, byte addresses 0xFFFFE, 0xFFFFF, 0xF0000.

Source files
------------

// File: rtl/nec_prefetch_queue.sv
// nec_prefetch_queue: instruction prefetch queue producer (8-byte IPQ, word or byte bus); PREFETCH_8BIT_BUS_EN selects the 8-bit bus
module nec_prefetch_queue (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_ce,
  input  logic        i_flush,
  input  logic [15:0] i_flush_pc,
  input  logic [15:0] i_ps,
  input  logic        i_consume,
  input  logic [3:0]  i_consume_len,
  output logic [63:0] o_ipq,
  output logic [3:0]  o_ipq_len,
  output logic [15:0] o_head_pc,
  output logic        o_fetch_req,
  output logic [19:0] o_fetch_addr,
  input  logic        i_fetch_ack,
  input  logic [15:0] i_fetch_data
);
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
  state_t      r_state;
  logic [7:0]  r_ipq [8];
  logic [3:0]  r_len;
  logic [15:0] r_head_pc;
  logic        r_req;
  logic [19:0] r_addr;
  logic [15:0] w_fetch_pc;
  logic [19:0] w_sum;
  logic [19:0] w_addr;
  logic [3:0]  w_free;
  logic [3:0]  w_need;
  logic [3:0]  w_written;
  logic [3:0]  w_take;
  logic [3:0]  w_len_next;
  logic [2:0]  w_slot;
  logic [2:0]  w_slot_hi;
  logic        w_accept;
  // head + len always names the next byte to fetch; consume moves both and leaves it unchanged
  assign w_fetch_pc = r_head_pc + {12'd0, r_len};
  assign w_sum      = {i_ps, 4'h0} + {4'h0, w_fetch_pc};
  assign w_free     = 4'd8 - r_len;
  assign w_slot     = w_fetch_pc[2:0];
  assign w_slot_hi  = w_slot + 3'd1;
  assign w_accept   = (r_state == REQ) && i_fetch_ack;
`ifdef PREFETCH_8BIT_BUS_EN
  assign w_addr     = w_sum;
  assign w_need     = 4'd1;
  assign w_written  = 4'd1;
`else
  localparam logic [3:0] FETCH_MIN = 4'd2;
  assign w_addr     = w_sum & ~20'h1;
  assign w_need     = w_fetch_pc[0] ? 4'd1 : FETCH_MIN;
  assign w_written  = w_fetch_pc[0] ? 4'd1 : 4'd2;
`endif
  // an over-long consume is clamped so the length cannot underflow
  assign w_take     = !i_consume ? 4'd0 : (i_consume_len > r_len) ? r_len : i_consume_len;
  assign w_len_next = r_len - w_take + (w_accept ? w_written : 4'd0);
  assign o_ipq_len    = r_len;
  assign o_head_pc    = r_head_pc;
  assign o_fetch_req  = r_req;
  assign o_fetch_addr = r_addr;
  genvar i;
  for (i = 0; i < 8; i++) begin : g_ipq
    assign o_ipq[8*i +: 8] = r_ipq[i];
  end
  // fetch FSM with queue bookkeeping; flush overrides consume and drops any ack data
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_len     <= '0;
      r_head_pc <= '0;
      for (int k = 0; k < 8; k++) r_ipq[k] <= 8'h00;
    end else if (i_ce) begin
      if (i_flush) begin
        r_head_pc <= i_flush_pc;
        r_len     <= '0;
      end else begin
        r_head_pc <= r_head_pc + {12'd0, w_take};
        r_len     <= w_len_next;
      end
      if (w_accept && !i_flush) begin
`ifdef PREFETCH_8BIT_BUS_EN
        r_ipq[w_slot] <= i_fetch_data[7:0];
`else
        if (w_fetch_pc[0]) r_ipq[w_slot] <= i_fetch_data[15:8];
        else begin
          r_ipq[w_slot]    <= i_fetch_data[7:0];
          r_ipq[w_slot_hi] <= i_fetch_data[15:8];
        end
`endif
      end
      case (r_state)
        IDLE: if (!i_flush && w_free >= w_need) begin
          r_req   <= 1'b1;
          r_addr  <= w_addr;
          r_state <= REQ;
        end
        REQ: if (i_fetch_ack) begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end else if (i_flush) r_state <= DISCARD;
        DISCARD: if (i_fetch_ack) begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  // the decoder must never retire more bytes than are valid
  a_consume_len: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (i_ce && i_consume && !i_flush) |-> (i_consume_len <= r_len));
endmodule

// File: tb/tb_nec_prefetch_queue.sv
// tb_nec_prefetch_queue: scoreboard bench for the prefetch queue (default 16-bit bus build)
module tb_nec_prefetch_queue;
  logic        clk = 1'b0;
  logic        reset_n, ce, flush, consume, fetch_ack, fetch_req;
  logic [15:0] flush_pc, ps, fetch_data, head_pc;
  logic [3:0]  consume_len, ipq_len;
  logic [63:0] ipq;
  logic [19:0] fetch_addr;
  typedef struct {logic [19:0] addr; logic [15:0] data; logic [3:0] len;} fetch_t;
  fetch_t sb[$];
  fetch_t e;
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  nec_prefetch_queue dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_ce(ce), .i_flush(flush), .i_flush_pc(flush_pc),
    .i_ps(ps), .i_consume(consume), .i_consume_len(consume_len), .o_ipq(ipq),
    .o_ipq_len(ipq_len), .o_head_pc(head_pc), .o_fetch_req(fetch_req),
    .o_fetch_addr(fetch_addr), .i_fetch_ack(fetch_ack), .i_fetch_data(fetch_data)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] ipqb(input int k);
    return ipq[8*k +: 8];
  endfunction
  task automatic push(input logic [19:0] a, input logic [15:0] d, input logic [3:0] l);
    sb.push_back('{a, d, l});
  endtask
  task automatic wait_req(output fetch_t x);
    int n = 0;
    x = sb.pop_front();
    while (!fetch_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, fetch_req}, 32'd1);
    chk("fetch_addr", {12'd0, fetch_addr}, {12'd0, x.addr});
  endtask
  task automatic drive_ack(input fetch_t x);
    fetch_ack  = 1'b1;
    fetch_data = x.data;
    @(posedge clk);
    #1 fetch_ack = 1'b0;
    consume = 1'b0;
    flush   = 1'b0;
    @(negedge clk);
    chk("ipq_len", {28'd0, ipq_len}, {28'd0, x.len});
  endtask
  task automatic serve();
    fetch_t x;
    wait_req(x);
    drive_ack(x);
  endtask
  task automatic step_flush(input logic [15:0] pc);
    flush    = 1'b1;
    flush_pc = pc;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    reset_n = 1'b0; ce = 1'b1; flush = 1'b1; flush_pc = 16'h0100; ps = 16'h1000;
    consume = 1'b0; consume_len = 4'd0; fetch_ack = 1'b0; fetch_data = 16'h0;
    @(negedge clk);
    chk("rst_len", {28'd0, ipq_len}, 32'd0);
    chk("rst_head", {16'd0, head_pc}, 32'd0);
    chk("rst_req", {31'd0, fetch_req}, 32'd0);
    chk("rst_addr", {12'd0, fetch_addr}, 32'd0);
    chk("rst_ipq0", {24'd0, ipqb(0)}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_head", {16'd0, head_pc}, 32'h0100);
    push(20'h10100, 16'h3412, 4'd2);
    push(20'h10102, 16'h7856, 4'd4);
    push(20'h10104, 16'hBC9A, 4'd6);
    push(20'h10106, 16'hF0DE, 4'd8);
    repeat (4) serve();
    repeat (5) @(negedge clk);
    chk("full_stall_req", {31'd0, fetch_req}, 32'd0);
    chk("full_len", {28'd0, ipq_len}, 32'd8);
    chk("ipq0", {24'd0, ipqb(0)}, 32'h12);
    chk("ipq1", {24'd0, ipqb(1)}, 32'h34);
    chk("ipq7", {24'd0, ipqb(7)}, 32'hF0);
    consume = 1'b1; consume_len = 4'd3;
    @(posedge clk);
    #1 consume = 1'b0;
    @(negedge clk);
    chk("consume_len", {28'd0, ipq_len}, 32'd5);
    chk("consume_head", {16'd0, head_pc}, 32'h0103);
    push(20'h10108, 16'hCDAB, 4'd7);
    serve();
    chk("wrap_slot0", {24'd0, ipqb(0)}, 32'hAB);
    chk("wrap_slot1", {24'd0, ipqb(1)}, 32'hCD);
    repeat (3) @(negedge clk);
    chk("need2_stall", {31'd0, fetch_req}, 32'd0);
    step_flush(16'h0103);
    chk("odd_flush_len", {28'd0, ipq_len}, 32'd0);
    push(20'h10102, 16'hAA55, 4'd1);
    serve();
    chk("odd_hi_slot3", {24'd0, ipqb(3)}, 32'hAA);
    push(20'h10104, 16'h2211, 4'd3);
    serve();
    chk("slot4", {24'd0, ipqb(4)}, 32'h11);
    chk("slot5", {24'd0, ipqb(5)}, 32'h22);
    push(20'h10106, 16'h0000, 4'd0);
    wait_req(e);
    flush = 1'b1; flush_pc = 16'h0200;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("discard_req_held", {31'd0, fetch_req}, 32'd1);
    chk("discard_len", {28'd0, ipq_len}, 32'd0);
    chk("discard_head", {16'd0, head_pc}, 32'h0200);
    fetch_ack = 1'b1; fetch_data = 16'hFFFF;
    @(posedge clk);
    #1 fetch_ack = 1'b0;
    @(negedge clk);
    chk("discard_done_req", {31'd0, fetch_req}, 32'd0);
    chk("discard_drop_len", {28'd0, ipq_len}, 32'd0);
    chk("discard_drop_slot6", {24'd0, ipqb(6)}, 32'hDE);
    push(20'h10200, 16'h4433, 4'd2);
    push(20'h10202, 16'h6655, 4'd4);
    repeat (2) serve();
    push(20'h10204, 16'h8877, 4'd4);
    wait_req(e);
    consume = 1'b1; consume_len = 4'd2;
    drive_ack(e);
    chk("cons_ack_head", {16'd0, head_pc}, 32'h0202);
    push(20'h10206, 16'h9999, 4'd0);
    wait_req(e);
    flush = 1'b1; flush_pc = 16'hFFFE; ps = 16'hF000;
    drive_ack(e);
    chk("flush_ack_req", {31'd0, fetch_req}, 32'd0);
    chk("flush_ack_head", {16'd0, head_pc}, 32'hFFFE);
    chk("flush_ack_drop", {24'd0, ipqb(6)}, 32'hDE);
    push(20'hFFFFE, 16'h0201, 4'd2);
    serve();
    chk("seg_slot6", {24'd0, ipqb(6)}, 32'h01);
    chk("seg_slot7", {24'd0, ipqb(7)}, 32'h02);
    push(20'hF0000, 16'h0403, 4'd4);
    serve();
    chk("pc_wrap_slot0", {24'd0, ipqb(0)}, 32'h03);
    push(20'hF0002, 16'h0605, 4'd6);
    wait_req(e);
    ce = 1'b0; fetch_ack = 1'b1; fetch_data = 16'h7777;
    @(posedge clk);
    #1 fetch_ack = 1'b0;
    @(negedge clk);
    chk("ce_hold_len", {28'd0, ipq_len}, 32'd4);
    chk("ce_hold_req", {31'd0, fetch_req}, 32'd1);
    ce = 1'b1;
    drive_ack(e);
    chk("ce_resume_slot2", {24'd0, ipqb(2)}, 32'h05);
    push(20'hF0004, 16'h0000, 4'd0);
    wait_req(e);
    reset_n = 1'b0; fetch_ack = 1'b1; fetch_data = 16'hDEAD;
    #1;
    chk("async_rst_req", {31'd0, fetch_req}, 32'd0);
    chk("async_rst_len", {28'd0, ipq_len}, 32'd0);
    chk("async_rst_head", {16'd0, head_pc}, 32'd0);
    chk("async_rst_addr", {12'd0, fetch_addr}, 32'd0);
    chk("async_rst_ipq0", {24'd0, ipqb(0)}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1 fetch_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_len", {28'd0, ipq_len}, 32'd0);
    chk("post_rst_req", {31'd0, fetch_req}, 32'd1);
    push(20'hF0000, 16'hBEEF, 4'd2);
    serve();
    chk("post_rst_slot0", {24'd0, ipqb(0)}, 32'hEF);
    chk("post_rst_slot1", {24'd0, ipqb(1)}, 32'hBE);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
